// File: rtl/pwm_ramp_if.sv
// Register-side bundle for pwm_ramp.
// Latency: none; it only carries wires.
// Backpressure: none; all writes are one-cycle strobes and outputs are levels or strobes.
//
// Signals: tgtld/ratld/wrtdata carry SPI register writes. enable/fault gate the channel.
//          pwmdata/pwmld feed the motor channel. busy/attarget/status report progress.
interface pwm_ramp_if;
   logic       tgtld;
   logic       ratld;
   logic [7:0] wrtdata;
   logic       enable;
   logic       fault;
   logic [7:0] pwmdata;
   logic       pwmld;
   logic       busy;
   logic       attarget;
   logic [7:0] status;

   // Register decoder / test side
   modport master (
      output tgtld, ratld, wrtdata, enable, fault,
      input  pwmdata, pwmld, busy, attarget, status
   );

   // Ramp block side
   modport slave (
      input  tgtld, ratld, wrtdata, enable, fault,
      output pwmdata, pwmld, busy, attarget, status
   );
endinterface

// File: rtl/pwm_ramp.sv
// Slew-rate limiter: steps a signed PWM duty one count per rate tick toward a target.
// Latency: the first pwmld comes N=(PRESCALE+1)*(ratediv+1) clocks after tgtld; fault/disable zero the output in 1 clock.
// Backpressure: none; the motor channel must accept every one-cycle pwmld strobe.
//
// Ports: clk, rstn (async active-low); bus (pwm_ramp_if.slave) carries the tgtld/ratld/wrtdata writes,
//        the enable and fault levels, and the pwmdata/pwmld/busy/attarget/status outputs.
// Option: define PWM_RAMP_DWELL_EN to add the zero-crossing dead-time dwell (DWELL_CYC clocks).
module pwm_ramp #(
   parameter int PRESCALE  = 255,
   parameter int DWELL_CYC = 1000
) (
   input  logic      clk,
   input  logic      rstn,
   pwm_ramp_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      STEP  = 2'b01,
      DWELL = 2'b10,
      FAULT = 2'b11
   } state_t;

   localparam int            PW  = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
   localparam logic [PW-1:0] PTC = PW'(PRESCALE);

   state_t        st_q, st_d;
   logic [7:0]    pwm_q, pwm_d;
   logic [7:0]    tgt_q, tgt_d;
   logic [7:0]    rdiv_q;
   logic          pld_q, pld_d;
   logic          flt_q, flt_d;
   logic [PW-1:0] pcnt_q;
   logic [7:0]    rcnt_q;
   logic          cnt_clr;
   logic          tick, step_tick;
   logic [7:0]    wr_clamp;
   logic [7:0]    step_val;
   logic          dwell_done;
   logic          dwell_en;

   // Both signs are non-zero and differ: a move between them must pass through zero.
   function automatic logic opposite(input logic [7:0] a, input logic [7:0] b);
      return (a != 8'd0) && (b != 8'd0) && (a[7] != b[7]);
   endfunction

   // -128 has no positive mirror, so the target range is kept symmetric.
   assign wr_clamp  = (bus.wrtdata == 8'h80) ? 8'h81 : bus.wrtdata;
   assign tick      = (pcnt_q == PTC) && (rcnt_q == rdiv_q);
   // A rate write restarts the period, so a coincident tick belongs to the old rate and is dropped.
   assign step_tick = tick && !bus.ratld;

`ifdef PWM_RAMP_DWELL_EN
   logic [15:0] dcnt_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)              dcnt_q <= 16'd0;
      else if (st_q != DWELL) dcnt_q <= 16'd0;
      else                    dcnt_q <= dcnt_q + 16'd1;
   end

   assign dwell_en   = 1'b1;
   assign dwell_done = (dcnt_q == 16'(DWELL_CYC - 1));
`else
   assign dwell_en   = 1'b0;
   // DWELL cannot be entered here; should it ever appear, leave it at once.
   assign dwell_done = (st_q == DWELL) && (DWELL_CYC >= 1);
`endif

   // Next value for one tick, always aimed at the target held before any same-cycle write.
   always_comb begin
      step_val = pwm_q;
      if (rdiv_q == 8'd0) begin
         step_val = opposite(pwm_q, tgt_q) ? 8'd0 : tgt_q;
      end else if ($signed(tgt_q) > $signed(pwm_q)) begin
         step_val = pwm_q + 8'd1;
      end else if ($signed(tgt_q) < $signed(pwm_q)) begin
         step_val = pwm_q - 8'd1;
      end
   end

   always_comb begin
      st_d    = st_q;
      pwm_d   = pwm_q;
      tgt_d   = tgt_q;
      pld_d   = 1'b0;
      flt_d   = flt_q;
      cnt_clr = 1'b0;
      if (bus.fault) begin
         st_d  = FAULT;
         pwm_d = 8'd0;
         tgt_d = 8'd0;
         pld_d = (pwm_q != 8'd0);
         flt_d = 1'b1;
      end else if (!bus.enable) begin
         // Only a tgtld leaves FAULT, so a disabled channel keeps it.
         st_d  = (st_q == FAULT) ? FAULT : IDLE;
         pwm_d = 8'd0;
         tgt_d = 8'd0;
         pld_d = (pwm_q != 8'd0);
      end else begin
         if (bus.tgtld) tgt_d = wr_clamp;
         case (st_q)
            IDLE: begin
               if (bus.tgtld && (wr_clamp != pwm_q)) begin
                  st_d    = STEP;
                  cnt_clr = 1'b1;
               end
            end
            FAULT: begin
               if (bus.tgtld) begin
                  st_d    = STEP;
                  cnt_clr = 1'b1;
                  flt_d   = 1'b0;
               end
            end
            DWELL: begin
               if (dwell_done) begin
                  st_d    = STEP;
                  cnt_clr = 1'b1;
               end
            end
            STEP: begin
               if (step_tick) begin
                  if (pwm_q == tgt_d) begin
                     // Retargeted onto the present value: settle without a load.
                     st_d = IDLE;
                  end else if (pwm_q != tgt_q) begin
                     // State follows the newest target, even though the step used the old one.
                     pwm_d = step_val;
                     pld_d = 1'b1;
                     if (step_val == tgt_d) begin
                        st_d = IDLE;
                     end else if (dwell_en && (step_val == 8'd0) && opposite(pwm_q, tgt_d)) begin
                        st_d = DWELL;
                     end
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         st_q  <= IDLE;
         pwm_q <= 8'd0;
         tgt_q <= 8'd0;
         pld_q <= 1'b0;
         flt_q <= 1'b0;
      end else begin
         st_q  <= st_d;
         pwm_q <= pwm_d;
         tgt_q <= tgt_d;
         pld_q <= pld_d;
         flt_q <= flt_d;
      end
   end

   // Rate divisor and the prescaler/rate counter pair that produces the tick.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdiv_q <= 8'h10;
         pcnt_q <= '0;
         rcnt_q <= 8'd0;
      end else begin
         if (bus.ratld) rdiv_q <= bus.wrtdata;
         if (bus.ratld || cnt_clr) begin
            pcnt_q <= '0;
            rcnt_q <= 8'd0;
         end else if (pcnt_q == PTC) begin
            pcnt_q <= '0;
            rcnt_q <= (rcnt_q == rdiv_q) ? 8'd0 : rcnt_q + 8'd1;
         end else begin
            pcnt_q <= pcnt_q + 1'b1;
         end
      end
   end

   // Every output below comes from a register, with no path from an input.
   assign bus.pwmdata  = pwm_q;
   assign bus.pwmld    = pld_q;
   assign bus.busy     = (st_q == STEP) || (st_q == DWELL);
   assign bus.attarget = (pwm_q == tgt_q) && (st_q != DWELL);
   assign bus.status   = {flt_q, bus.busy, bus.attarget, (st_q == DWELL), 2'b00, st_q};
endmodule

// File: tb/tb_pwm_ramp.sv
// Directed bench for pwm_ramp: PRESCALE=3, DWELL_CYC=10, ratediv=1 (N=8) unless stated.
// Latency: inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Backpressure: none.
module tb_pwm_ramp;
   logic clk = 1'b0;
   logic rstn;
   int   vecs = 0;
   int   errs = 0;
   int   cyc  = 0;
   int   nld;

   pwm_ramp_if bus ();

   pwm_ramp #(.PRESCALE(3), .DWELL_CYC(10)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic clk1();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One-cycle target write; the sampling edge becomes cycle 0.
   task automatic tgt(input logic [7:0] v);
      bus.tgtld   = 1'b1;
      bus.wrtdata = v;
      clk1();
      bus.tgtld   = 1'b0;
      cyc         = 0;
   endtask

   task automatic rate(input logic [7:0] v);
      bus.ratld   = 1'b1;
      bus.wrtdata = v;
      clk1();
      bus.ratld   = 1'b0;
   endtask

   // Wait (bounded) for the next pwmld, then check its cycle and value.
   task automatic wait_ld(input string tag, input logic [7:0] val, input int at);
      int n = 0;
      do begin
         clk1();
         n++;
      end while (bus.pwmld !== 1'b1 && n < 200);
      chk({tag, " cycle"}, cyc, at);
      chk({tag, " pwmdata"}, bus.pwmdata, val);
   endtask

   task automatic count_ld(input int ncyc);
      nld = 0;
      for (int i = 0; i < ncyc; i++) begin
         clk1();
         if (bus.pwmld === 1'b1) nld++;
      end
   endtask

   initial begin
      rstn        = 1'b0;
      bus.tgtld   = 1'b0;
      bus.ratld   = 1'b0;
      bus.wrtdata = 8'h00;
      bus.enable  = 1'b1;
      bus.fault   = 1'b0;

      // Reset values
      clk1(); clk1();
      chk("rst pwmdata", bus.pwmdata, 8'h00);
      chk("rst status", bus.status, 8'h20);
      chk("rst attarget", bus.attarget, 1'b1);
      chk("rst busy", bus.busy, 1'b0);
      rstn = 1'b1;
      count_ld(100);
      chk("idle no pwmld", nld, 0);
      chk("idle status", bus.status, 8'h20);

      rate(8'h01);

      // Ramp up 0 -> 4
      tgt(8'h04);
      chk("up status busy", bus.status, 8'h41);
      wait_ld("up1", 8'h01, 8);
      wait_ld("up2", 8'h02, 16);
      wait_ld("up3", 8'h03, 24);
      wait_ld("up4", 8'h04, 32);
      chk("up attarget", bus.attarget, 1'b1);
      chk("up busy", bus.busy, 1'b0);
      chk("up status idle", bus.status, 8'h20);

      // Down to +2, then reverse to -2
      tgt(8'h02);
      wait_ld("dn3", 8'h03, 8);
      wait_ld("dn2", 8'h02, 16);
      tgt(8'hFE);
      wait_ld("rev p1", 8'h01, 8);
      wait_ld("rev 0", 8'h00, 16);
`ifdef PWM_RAMP_DWELL_EN
      chk("rev dwell status", bus.status, 8'h52);
      wait_ld("rev m1", 8'hFF, 34);
      wait_ld("rev m2", 8'hFE, 42);
`else
      chk("rev step status", bus.status, 8'h41);
      wait_ld("rev m1", 8'hFF, 24);
      wait_ld("rev m2", 8'hFE, 32);
`endif
      chk("rev attarget", bus.attarget, 1'b1);

      // Back to 0 (no dwell: target is zero), then ramp toward +5 and fault at +3
      tgt(8'h00);
      wait_ld("z m1", 8'hFF, 8);
      wait_ld("z 0", 8'h00, 16);
      tgt(8'h05);
      wait_ld("f1", 8'h01, 8);
      wait_ld("f2", 8'h02, 16);
      wait_ld("f3", 8'h03, 24);
      bus.fault = 1'b1;
      clk1();
      chk("fault cycle", cyc, 25);
      chk("fault pwmld", bus.pwmld, 1'b1);
      chk("fault pwmdata", bus.pwmdata, 8'h00);
      chk("fault status", bus.status, 8'hA3);
      bus.tgtld   = 1'b1;
      bus.wrtdata = 8'h05;
      clk1();
      bus.tgtld   = 1'b0;
      count_ld(20);
      chk("fault tgtld ignored", nld, 0);
      chk("fault hold status", bus.status, 8'hA3);
      bus.fault = 1'b0;
      count_ld(5);
      chk("fault stays", bus.status, 8'hA3);
      tgt(8'h05);
      chk("fault exit status", bus.status, 8'h41);
      wait_ld("r1", 8'h01, 8);
      wait_ld("r2", 8'h02, 16);
      wait_ld("r3", 8'h03, 24);
      wait_ld("r4", 8'h04, 32);
      wait_ld("r5", 8'h05, 40);

      // Bypass (ratediv=0): jump to 0, then clamped -128 -> -127
      rate(8'h00);
      tgt(8'h00);
      wait_ld("byp 0", 8'h00, 4);
      tgt(8'h80);
      wait_ld("clamp", 8'h81, 4);
      count_ld(20);
      chk("clamp single pwmld", nld, 0);
      chk("clamp status", bus.status, 8'h20);

      // Disable zeroes the output; tgtld is ignored while disabled
      bus.enable = 1'b0;
      clk1();
      chk("dis pwmld", bus.pwmld, 1'b1);
      chk("dis pwmdata", bus.pwmdata, 8'h00);
      chk("dis status", bus.status, 8'h20);
      bus.tgtld   = 1'b1;
      bus.wrtdata = 8'h05;
      clk1();
      bus.tgtld   = 1'b0;
      count_ld(20);
      chk("dis tgtld ignored", nld, 0);
      bus.enable = 1'b1;

      // tgtld 0 coinciding with the step tick from +2 toward +5
      rate(8'h01);
      tgt(8'h02);
      wait_ld("s1", 8'h01, 8);
      wait_ld("s2", 8'h02, 16);
      tgt(8'h05);
      for (int i = 0; i < 7; i++) clk1();
      bus.tgtld   = 1'b1;
      bus.wrtdata = 8'h00;
      clk1();
      bus.tgtld   = 1'b0;
      chk("sim cycle", cyc, 8);
      chk("sim pwmld", bus.pwmld, 1'b1);
      chk("sim pwmdata", bus.pwmdata, 8'h03);
      wait_ld("sd2", 8'h02, 16);
      wait_ld("sd1", 8'h01, 24);
      wait_ld("sd0", 8'h00, 32);
      chk("sim status", bus.status, 8'h20);

      // Reset mid-ramp; ratediv returns to 16 so N = 4*17 = 68
      tgt(8'h05);
      wait_ld("m1", 8'h01, 8);
      rstn = 1'b0;
      #1;
      chk("mid rst pwmdata", bus.pwmdata, 8'h00);
      chk("mid rst pwmld", bus.pwmld, 1'b0);
      chk("mid rst status", bus.status, 8'h20);
      clk1();
      rstn = 1'b1;
      clk1();
      tgt(8'h01);
      wait_ld("rst rate", 8'h01, 68);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
